urv_mem_arb2: RTL
=================

# urv_mem_arb2

Two-requester arbiter that shares one burst memory target (the SRAM burst bridge) between the instruction-fetch port and the load/store port. It grants one `mem_req_t` request at a time with round-robin priority and holds the grant until the final response beat (`resp_last`). It steers every response beat back to the owning requester, and checks each burst's beat count against the `resp_last` it receives. It sits between the core memory ports and the single `mem_req`/`mem_resp` slave port.

## Interface
- `FIRST_PRIO`, default 0: requester that holds priority after reset (0 = m0/ifetch, 1 = m1/lsu).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `m0_req_valid`  in  1  requester 0 request valid.
- `m0_req_ready`  out  1  requester 0 request accepted this cycle.
- `m0_req`  in  `$bits(mem_req_t)`  requester 0 request (`req_type`, `req_addr`, `req_data`, `req_mask`, `req_burst`).
- `m0_resp_valid`  out  1  response beat for requester 0.
- `m0_resp_ready`  in  1  requester 0 accepts the beat.
- `m0_resp`  out  `$bits(mem_resp_t)`  response beat (`resp_data`, `resp_type`, `resp_last`).
- `m1_req_valid`, `m1_req_ready`, `m1_req`, `m1_resp_valid`, `m1_resp_ready`, `m1_resp`: same as m0, for requester 1.
- `s_req_valid`  out  1  request to the target.
- `s_req_ready`  in  1  target accepts the request.
- `s_req`  out  `$bits(mem_req_t)`  forwarded request; identical to the granted requester's request.
- `s_resp_valid`  in  1  target response beat.
- `s_resp_ready`  out  1  response accepted; driven by the owner's `resp_ready`.
- `s_resp`  in  `$bits(mem_resp_t)`  target response beat.
- `err_burst`  out  1  one-cycle pulse when a burst's beat count and `resp_last` disagree.

## Operation
- Registered state:
  - FSM: IDLE or BUSY.
  - `owner`: 1 bit.
  - `prio`: 1 bit.
  - `beat_cnt`: width of `req_burst`.
  - `err_burst` flop.
- IDLE arbitration, combinational:
  - If exactly one requester is valid, it is granted.
  - If both are valid, the requester indexed by `prio` is granted.
  - `s_req_valid` = any requester valid.
  - `s_req` = the granted requester's request.
  - The granted requester's `req_ready` = `s_req_ready`; the other requester's `req_ready` = 0.
- IDLE → BUSY when `s_req_valid & s_req_ready`. On that edge:
  - `owner` ← granted index.
  - `prio` ← the other index.
  - `beat_cnt` ← granted `req_burst`.
- In BUSY:
  - `s_req_valid` = 0; both `req_ready` = 0.
  - Requests stay pending, and a pending request must be held stable by its requester.
- Response routing, BUSY only:
  - `m{owner}_resp_valid` = `s_resp_valid`; `m{owner}_resp` = `s_resp`.
  - `s_resp_ready` = `m{owner}_resp_ready`.
  - The non-owner's `resp_valid` = 0; its `resp` payload is don't-care but driven from `s_resp`.
  - In IDLE, `s_resp_ready` = 1 and both `resp_valid` = 0. Stray beats are dropped and raise `err_burst`.
- On each response handshake (`s_resp_valid & s_resp_ready`) in BUSY:
  - `beat_cnt` decrements by 1.
  - If `s_resp.resp_last` != (`beat_cnt` == 1), `err_burst` pulses next cycle.
- BUSY → IDLE on the handshake where `resp_last` = 1. This also applies when `resp_last` arrives early (with the error pulse).
  - If `beat_cnt` reaches 0 without `resp_last`, the FSM stays BUSY until `resp_last`.
  - Each further beat in that case also flags `err_burst`.
- `req_burst` = 0 is illegal; behaviour is undefined and not checked.
- Only one transaction is outstanding at a time. A new grant is issued no earlier than the cycle after the last beat's handshake.

## Timing
- Reset values:
  - FSM = IDLE; `owner` = 0; `prio` = `FIRST_PRIO`; `beat_cnt` = 0; `err_burst` = 0.
  - Outputs after reset: `s_req_valid` = 0 while no requester is valid. Both `resp_valid` = 0.
- Request path is combinational: `m*_req_valid` → `s_req_valid`, and `s_req_ready` → `m*_req_ready`. There is no added request latency.
- Response path is combinational with zero added latency. Backpressure from the owner is passed straight to the target.
- Dead time between bursts is 1 cycle: last-beat handshake at cycle N, next grant possible at N+1.
- `prio` changes only on an accepted grant. It therefore stays stable while a valid request waits for `s_req_ready`.
- Reset asserted mid-burst: all state clears asynchronously. Outstanding target beats after reset are treated as stray beats (dropped, `err_burst`).

## Test plan
- Single requester: m0 request with burst=4, addr=0x100 → `s_req` matches `m0_req`; 4 beats reach m0 only; `resp_last` on beat 4; IDLE the next cycle; `err_burst` = 0.
- Contention: m0 and m1 both valid from reset with `FIRST_PRIO` = 0 → m0 is granted (burst 2); m1 is granted at the cycle after m0's last beat; a subsequent simultaneous request goes to m0 (round-robin alternation over 8 rounds).
- Backpressure: m1 owns a burst of 3 and holds `m1_resp_ready` = 0 for 2 cycles mid-burst → `s_resp_ready` = 0 during those cycles; no beat is lost; data order is preserved.
- Target stall: `s_req_ready` = 0 for 3 cycles while both requesters are valid → the grant stays on the `prio` requester; `m*_req_ready` = 0 throughout; grant proceeds on the first ready.
- Burst mismatch: burst=4 with `resp_last` injected on beat 2 → `err_burst` pulses once; FSM returns to IDLE. Stray beat while IDLE → dropped, `err_burst` pulses.
- Reset mid-burst: `rstn` low during beat 2 of 4 → all outputs take their reset values immediately; after release the first grant follows `FIRST_PRIO`.

Source files
------------

// File: rtl/urv_mem_arb2.sv
// urv_mem_arb2: round-robin arbiter sharing one burst memory target
// between the ifetch (m0) and load/store (m1) ports.
package urv_mem_pkg;
   localparam int BURST_W = 4;

   typedef struct packed {
      logic               req_type;
      logic [31:0]        req_addr;
      logic [31:0]        req_data;
      logic [3:0]         req_mask;
      logic [BURST_W-1:0] req_burst;
   } mem_req_t;

   typedef struct packed {
      logic [31:0] resp_data;
      logic        resp_type;
      logic        resp_last;
   } mem_resp_t;
endpackage

module urv_mem_arb2
   import urv_mem_pkg::*;
#(
   parameter bit FIRST_PRIO = 1'b0
) (
   input  logic      clk,
   input  logic      rstn,
   input  logic      m0_req_valid,
   output logic      m0_req_ready,
   input  mem_req_t  m0_req,
   output logic      m0_resp_valid,
   input  logic      m0_resp_ready,
   output mem_resp_t m0_resp,
   input  logic      m1_req_valid,
   output logic      m1_req_ready,
   input  mem_req_t  m1_req,
   output logic      m1_resp_valid,
   input  logic      m1_resp_ready,
   output mem_resp_t m1_resp,
   output logic      s_req_valid,
   input  logic      s_req_ready,
   output mem_req_t  s_req,
   input  logic      s_resp_valid,
   output logic      s_resp_ready,
   input  mem_resp_t s_resp,
   output logic      err_burst
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t             state, state_nx;
   logic               owner, owner_nx;
   logic               prio, prio_nx;
   logic               gnt;
   logic               err_nx;
   logic [BURST_W-1:0] beat_cnt, cnt_nx;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         owner     <= 1'b0;
         prio      <= FIRST_PRIO;
         beat_cnt  <= '0;
         err_burst <= 1'b0;
      end else begin
         state     <= state_nx;
         owner     <= owner_nx;
         prio      <= prio_nx;
         beat_cnt  <= cnt_nx;
         err_burst <= err_nx;
      end
   end

   always_comb begin
      state_nx      = state;
      owner_nx      = owner;
      prio_nx       = prio;
      cnt_nx        = beat_cnt;
      err_nx        = 1'b0;
      gnt           = (m0_req_valid & m1_req_valid) ? prio : m1_req_valid;
      s_req         = gnt ? m1_req : m0_req;
      s_req_valid   = 1'b0;
      m0_req_ready  = 1'b0;
      m1_req_ready  = 1'b0;
      s_resp_ready  = 1'b1;
      m0_resp_valid = 1'b0;
      m1_resp_valid = 1'b0;
      m0_resp       = s_resp;
      m1_resp       = s_resp;
      unique case (state)
         IDLE: begin
            s_req_valid  = m0_req_valid | m1_req_valid;
            m0_req_ready = s_req_valid & ~gnt & s_req_ready;
            m1_req_ready = s_req_valid & gnt & s_req_ready;
            // any beat arriving with no owner is stray
            err_nx = s_resp_valid;
            if (s_req_valid && s_req_ready) begin
               state_nx = BUSY;
               owner_nx = gnt;
               prio_nx  = ~gnt;
               cnt_nx   = s_req.req_burst;
            end
         end
         BUSY: begin
            s_resp_ready  = owner ? m1_resp_ready : m0_resp_ready;
            m0_resp_valid = ~owner & s_resp_valid;
            m1_resp_valid = owner & s_resp_valid;
            if (s_resp_valid && s_resp_ready) begin
               // saturate so overrun beats keep flagging
               cnt_nx = (beat_cnt == '0) ? '0 : beat_cnt - 1'b1;
               err_nx = (beat_cnt == '0) |
                        (s_resp.resp_last != (beat_cnt == 1));
               if (s_resp.resp_last) state_nx = IDLE;
            end
         end
      endcase
   end

endmodule
